uart_fifo_top: RTL and testbench
================================

Name: uart_fifo_top

Overview:
Parametrised UART with independent TX and RX FIFOs and configurable frame format: data bits, optional odd/even parity, 1 or 2 stop bits. It generalises the fixed 8N1 single-byte UART to buffered, error-reporting operation. It sits between the core's peripheral bus logic and the pins. The bus side sees FIFO-style push/pop with status flags and sticky error bits.

Parameters:
clk_freq, 1000000, system clock frequency in Hz
baud_rate, 9600, line rate; BIT_TICKS = clk_freq/baud_rate (integer division, must be >= 4)
data_bits, 8, data bits per frame, legal 5..9
parity, 0, 0 = none, 1 = odd, 2 = even
stop_bits, 1, stop bits transmitted, 1 or 2
fifo_depth, 16, entries per FIFO, power of 2, >= 2

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  asynchronous, active-high reset
rx  in  1  serial input, asynchronous to clk
tx  out  1  serial output, idle high
tx_data  in  data_bits  word to transmit
tx_wr  in  1  push tx_data into TX FIFO
tx_full  out  1  TX FIFO full
tx_empty  out  1  TX FIFO empty and TX FSM idle
rx_data  out  data_bits  head of RX FIFO (first-word fall-through)
rx_valid  out  1  RX FIFO non-empty
rx_rd  in  1  pop RX FIFO
rx_level  out  clog2(fifo_depth)+1  RX FIFO occupancy
parity_err  out  1  sticky: parity mismatch seen
frame_err  out  1  sticky: stop bit sampled low
overrun  out  1  sticky: RX word dropped because RX FIFO full
err_clr  in  1  clears all three sticky flags

Behaviour:
- Reset values: tx = 1, tx_full = 0, tx_empty = 1, rx_valid = 0, rx_level = 0, rx_data = 0, all error flags 0. Both FIFOs emptied and both FSMs set to IDLE immediately, including mid-frame.
- TX FIFO: tx_wr with tx_full = 0 writes. tx_wr with tx_full = 1 is ignored, even if the FSM pops in the same cycle.
- TX FSM states:
  - IDLE: tx = 1. If FIFO non-empty, pop the head into the shift register and enter START on the next edge.
  - START: tx = 0.
  - DATA: LSB first, data_bits bits.
  - PARITY: present only if parity != 0. Odd parity makes the total count of ones including the parity bit odd; even makes it even.
  - STOP: tx = 1 for stop_bits bit times, then IDLE.
  - Every bit is held exactly BIT_TICKS cycles. Back-to-back frames are separated by exactly one clk cycle of idle.
- RX input: two-flop synchroniser, both flops reset to 1.
- RX FSM states:
  - IDLE: wait for synchronised rx = 0. After a frame error, first wait for rx = 1 (break handling).
  - START: count BIT_TICKS/2 cycles, then resample. If 1, treat as a glitch and return to IDLE with no flags. If 0, enter DATA.
  - DATA: sample every BIT_TICKS cycles, data_bits samples, LSB first.
  - PARITY: one sample if enabled. A mismatch sets parity_err.
  - STOP: sample once after BIT_TICKS. If 1, push the word. If 0, set frame_err and discard the word. Only the first stop bit is checked. Return to IDLE on the next cycle.
- RX FIFO push:
  - Parity-errored words are still pushed.
  - A push when full with no pop in the same cycle drops the word and sets overrun.
  - A push when full with a simultaneous rx_rd is accepted.
  - rx_rd with rx_valid = 0 is ignored.
- Sticky flags: err_clr clears them. A set event in the same cycle as err_clr wins (flag ends at 1).
- Latency: the pushed word is visible on rx_data/rx_valid the cycle after the stop sample. rx_level updates in the same cycle.

Test Plan:
1. Reset: assert rst mid-transmission -> tx = 1 asynchronously, tx_empty = 1, rx_valid = 0, rx_level = 0, all flags 0.
2. TX format: clk_freq = 1000000, baud_rate = 100000 (BIT_TICKS = 10), parity = 2. Write 0xA5 -> tx low 10 cycles, then 1,0,1,0,0,1,0,1, parity 0, stop 1. 110 cycles per frame, tx_empty returns to 1.
3. Loopback tx->rx: write 0x00, 0xFF, 0x3C on consecutive cycles -> frames 1 cycle apart. rx_data pops 0x00, 0xFF, 0x3C in order. No flags set.
4. Overrun: send 17 frames without rx_rd, fifo_depth = 16 -> rx_level = 16, overrun = 1, first 16 words intact. Then rx_rd concurrent with an arriving 18th frame's push -> accepted.
5. Errors:
   - Frame 0x55 with inverted parity bit -> word pushed, parity_err = 1.
   - Stop bit driven 0 -> frame_err = 1, rx_level unchanged.
   - err_clr -> both flags 0.
6. Glitch: rx low for 3 cycles (< BIT_TICKS/2 = 5) -> no push, no flags. A following valid frame 0x81 is received correctly.

Source files
------------

// File: rtl/uart_fifo_top.sv
// Buffered UART with configurable frame format (data bits, parity, stop bits).
// TX and RX each have a FIFO; the RX side reports parity/frame/overrun as sticky flags.
module uart_fifo_top #(
  parameter int clk_freq   = 1000000,
  parameter int baud_rate  = 9600,
  parameter int data_bits  = 8,
  parameter int parity     = 0,
  parameter int stop_bits  = 1,
  parameter int fifo_depth = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          rx,
  output logic                          tx,
  input  logic [data_bits-1:0]          tx_data,
  input  logic                          tx_wr,
  output logic                          tx_full,
  output logic                          tx_empty,
  output logic [data_bits-1:0]          rx_data,
  output logic                          rx_valid,
  input  logic                          rx_rd,
  output logic [$clog2(fifo_depth):0]   rx_level,
  output logic                          parity_err,
  output logic                          frame_err,
  output logic                          overrun,
  input  logic                          err_clr
);

  localparam int BIT_TICKS = clk_freq / baud_rate;
  localparam int HALF      = BIT_TICKS / 2;
  localparam int TW        = $clog2(BIT_TICKS);
  localparam int BW        = $clog2(data_bits);
  localparam int AW        = $clog2(fifo_depth);
  localparam logic          ODD      = (parity == 1);
  localparam logic [AW:0]   DEPTH_L  = (AW+1)'(fifo_depth);
  localparam logic [TW-1:0] TICK_END = TW'(BIT_TICKS - 1);
  localparam logic [TW-1:0] TICK_MID = TW'(HALF - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(data_bits - 1);
  localparam logic [BW-1:0] LAST_STP = BW'(stop_bits - 1);

  // ---------------- TX FIFO ----------------
  logic [data_bits-1:0] txf_mem [fifo_depth];
  logic [AW-1:0]        txf_wp, txf_rp;
  logic [AW:0]          txf_cnt;
  logic                 txf_push, txf_empty, tx_pop;
  logic [data_bits-1:0] txf_head;

  assign tx_full   = (txf_cnt == DEPTH_L);
  assign txf_empty = (txf_cnt == '0);
  assign txf_push  = tx_wr && !tx_full;
  assign txf_head  = txf_mem[txf_rp];

  always_ff @(posedge clk) begin
    if (txf_push) txf_mem[txf_wp] <= tx_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      txf_wp  <= '0;
      txf_rp  <= '0;
      txf_cnt <= '0;
    end else begin
      if (txf_push) txf_wp <= txf_wp + AW'(1);
      if (tx_pop)   txf_rp <= txf_rp + AW'(1);
      case ({txf_push, tx_pop})
        2'b10:   txf_cnt <= txf_cnt + (AW+1)'(1);
        2'b01:   txf_cnt <= txf_cnt - (AW+1)'(1);
        default: txf_cnt <= txf_cnt;
      endcase
    end
  end

  // ---------------- TX FSM ----------------
  typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_t;
  tx_state_t            tx_state, tx_state_nx;
  logic [TW-1:0]        tx_tick, tx_tick_nx;
  logic [BW-1:0]        tx_bit, tx_bit_nx;
  logic [data_bits-1:0] tx_shift, tx_shift_nx;
  logic                 tx_par, tx_par_nx;
  logic                 tx_out, tx_end;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_state <= TX_IDLE;
      tx_tick  <= '0;
      tx_bit   <= '0;
      tx_shift <= '0;
      tx_par   <= 1'b0;
    end else begin
      tx_state <= tx_state_nx;
      tx_tick  <= tx_tick_nx;
      tx_bit   <= tx_bit_nx;
      tx_shift <= tx_shift_nx;
      tx_par   <= tx_par_nx;
    end
  end

  always_comb begin
    tx_state_nx = tx_state;
    tx_tick_nx  = tx_tick;
    tx_bit_nx   = tx_bit;
    tx_shift_nx = tx_shift;
    tx_par_nx   = tx_par;
    tx_pop      = 1'b0;
    tx_out      = 1'b1;
    tx_end      = (tx_tick == TICK_END);
    if (tx_state != TX_IDLE) tx_tick_nx = tx_end ? '0 : tx_tick + TW'(1);
    case (tx_state)
      TX_IDLE: begin
        if (!txf_empty) begin
          tx_pop      = 1'b1;
          tx_shift_nx = txf_head;
          tx_par_nx   = (^txf_head) ^ ODD;
          tx_tick_nx  = '0;
          tx_state_nx = TX_START;
        end
      end
      TX_START: begin
        tx_out = 1'b0;
        if (tx_end) begin
          tx_bit_nx   = '0;
          tx_state_nx = TX_DATA;
        end
      end
      TX_DATA: begin
        tx_out = tx_shift[0];
        if (tx_end) begin
          tx_shift_nx = tx_shift >> 1;
          if (tx_bit == LAST_BIT) begin
            tx_bit_nx   = '0;
            tx_state_nx = (parity != 0) ? TX_PARITY : TX_STOP;
          end else begin
            tx_bit_nx = tx_bit + BW'(1);
          end
        end
      end
      TX_PARITY: begin
        tx_out = tx_par;
        if (tx_end) begin
          tx_bit_nx   = '0;
          tx_state_nx = TX_STOP;
        end
      end
      TX_STOP: begin
        if (tx_end) begin
          if (tx_bit == LAST_STP) tx_state_nx = TX_IDLE;
          else                    tx_bit_nx   = tx_bit + BW'(1);
        end
      end
      default: tx_state_nx = TX_IDLE;
    endcase
  end

  // Combinational from state so reset forces the line high without waiting for a clock.
  assign tx       = tx_out;
  assign tx_empty = txf_empty && (tx_state == TX_IDLE);

  // ---------------- RX synchroniser ----------------
  logic rx_s1, rx_s2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_s1 <= 1'b1;
      rx_s2 <= 1'b1;
    end else begin
      rx_s1 <= rx;
      rx_s2 <= rx_s1;
    end
  end

  // ---------------- RX FSM ----------------
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP, RX_BREAK} rx_state_t;
  rx_state_t            rx_state, rx_state_nx;
  logic [TW-1:0]        rx_tick, rx_tick_nx;
  logic [BW-1:0]        rx_bit, rx_bit_nx;
  logic [data_bits-1:0] rx_shift, rx_shift_nx;
  logic                 rx_push, set_par, set_frame, rx_end;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_state <= RX_IDLE;
      rx_tick  <= '0;
      rx_bit   <= '0;
      rx_shift <= '0;
    end else begin
      rx_state <= rx_state_nx;
      rx_tick  <= rx_tick_nx;
      rx_bit   <= rx_bit_nx;
      rx_shift <= rx_shift_nx;
    end
  end

  always_comb begin
    rx_state_nx = rx_state;
    rx_tick_nx  = rx_tick;
    rx_bit_nx   = rx_bit;
    rx_shift_nx = rx_shift;
    rx_push     = 1'b0;
    set_par     = 1'b0;
    set_frame   = 1'b0;
    rx_end      = (rx_tick == TICK_END);
    case (rx_state)
      RX_IDLE: begin
        if (!rx_s2) begin
          rx_tick_nx  = '0;
          rx_state_nx = RX_START;
        end
      end
      RX_START: begin
        if (rx_tick == TICK_MID) begin
          rx_tick_nx  = '0;
          rx_bit_nx   = '0;
          rx_state_nx = rx_s2 ? RX_IDLE : RX_DATA;
        end else begin
          rx_tick_nx = rx_tick + TW'(1);
        end
      end
      RX_DATA: begin
        rx_tick_nx = rx_end ? '0 : rx_tick + TW'(1);
        if (rx_end) begin
          rx_shift_nx = {rx_s2, rx_shift[data_bits-1:1]};
          if (rx_bit == LAST_BIT) begin
            rx_bit_nx   = '0;
            rx_state_nx = (parity != 0) ? RX_PARITY : RX_STOP;
          end else begin
            rx_bit_nx = rx_bit + BW'(1);
          end
        end
      end
      RX_PARITY: begin
        rx_tick_nx = rx_end ? '0 : rx_tick + TW'(1);
        if (rx_end) begin
          set_par     = ((^rx_shift) ^ rx_s2) != ODD;
          rx_state_nx = RX_STOP;
        end
      end
      RX_STOP: begin
        rx_tick_nx = rx_end ? '0 : rx_tick + TW'(1);
        if (rx_end) begin
          if (rx_s2) begin
            rx_push     = 1'b1;
            rx_state_nx = RX_IDLE;
          end else begin
            set_frame   = 1'b1;
            rx_state_nx = RX_BREAK;
          end
        end
      end
      RX_BREAK: begin
        if (rx_s2) rx_state_nx = RX_IDLE;
      end
      default: rx_state_nx = RX_IDLE;
    endcase
  end

  // ---------------- RX FIFO ----------------
  logic [data_bits-1:0] rxf_mem [fifo_depth];
  logic [AW-1:0]        rxf_wp, rxf_rp;
  logic [AW:0]          rxf_cnt;
  logic                 rxf_full, rxf_push, rxf_pop, set_ovr;

  assign rxf_full = (rxf_cnt == DEPTH_L);
  assign rx_valid = (rxf_cnt != '0);
  assign rxf_pop  = rx_rd && rx_valid;
  // A full FIFO still accepts a word when a pop frees a slot in the same cycle.
  assign rxf_push = rx_push && (!rxf_full || rxf_pop);
  assign set_ovr  = rx_push && rxf_full && !rxf_pop;
  assign rx_data  = rx_valid ? rxf_mem[rxf_rp] : '0;
  assign rx_level = rxf_cnt;

  always_ff @(posedge clk) begin
    if (rxf_push) rxf_mem[rxf_wp] <= rx_shift;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rxf_wp  <= '0;
      rxf_rp  <= '0;
      rxf_cnt <= '0;
    end else begin
      if (rxf_push) rxf_wp <= rxf_wp + AW'(1);
      if (rxf_pop)  rxf_rp <= rxf_rp + AW'(1);
      case ({rxf_push, rxf_pop})
        2'b10:   rxf_cnt <= rxf_cnt + (AW+1)'(1);
        2'b01:   rxf_cnt <= rxf_cnt - (AW+1)'(1);
        default: rxf_cnt <= rxf_cnt;
      endcase
    end
  end

  // ---------------- Sticky error flags (set beats clear) ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      if (set_par)        parity_err <= 1'b1;
      else if (err_clr)   parity_err <= 1'b0;
      if (set_frame)      frame_err  <= 1'b1;
      else if (err_clr)   frame_err  <= 1'b0;
      if (set_ovr)        overrun    <= 1'b1;
      else if (err_clr)   overrun    <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_fifo_top.sv
// Directed bench for uart_fifo_top: 8E1 frames at 10 clocks per bit, 16-deep FIFOs.
module tb_uart_fifo_top;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx_drv = 1'b1;
  logic       loop_en = 1'b0;
  logic       rx_line;
  logic       tx;
  logic [7:0] tx_data = '0;
  logic       tx_wr = 1'b0;
  logic       tx_full, tx_empty;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_rd = 1'b0;
  logic [4:0] rx_level;
  logic       parity_err, frame_err, overrun;
  logic       err_clr = 1'b0;
  logic [6:0] status;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  assign rx_line = loop_en ? tx : rx_drv;
  assign status  = {tx, tx_full, tx_empty, rx_valid, parity_err, frame_err, overrun};

  uart_fifo_top #(
    .clk_freq  (1000000),
    .baud_rate (100000),
    .data_bits (8),
    .parity    (2),
    .stop_bits (1),
    .fifo_depth(16)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx_line),
    .tx        (tx),
    .tx_data   (tx_data),
    .tx_wr     (tx_wr),
    .tx_full   (tx_full),
    .tx_empty  (tx_empty),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_rd     (rx_rd),
    .rx_level  (rx_level),
    .parity_err(parity_err),
    .frame_err (frame_err),
    .overrun   (overrun),
    .err_clr   (err_clr)
  );

  task automatic write_word(input logic [7:0] d);
    @(posedge clk); #1 tx_wr = 1'b1; tx_data = d;
    @(posedge clk); #1 tx_wr = 1'b0;
  endtask

  task automatic pop_word();
    @(posedge clk); #1 rx_rd = 1'b1;
    @(posedge clk); #1 rx_rd = 1'b0;
  endtask

  task automatic pulse_clr();
    @(posedge clk); #1 err_clr = 1'b1;
    @(posedge clk); #1 err_clr = 1'b0;
  endtask

  // Drives one 8E1 frame on rx_drv; optional bad parity, stop level, and err_clr
  // aligned with the receiver's stop-bit sample.
  task automatic send_frame(input logic [7:0] d, input logic bad_par, input logic stop_v,
                            input logic clr_at_stop);
    logic [10:0] bits;
    bits = {stop_v, (^d) ^ bad_par, d, 1'b0};
    for (int b = 0; b < 11; b++) begin
      for (int c = 0; c < 10; c++) begin
        @(posedge clk); #1 rx_drv = bits[b];
        err_clr = clr_at_stop && (b == 10) && (c == 7);
      end
    end
    @(posedge clk); #1 rx_drv = 1'b1; err_clr = 1'b0;
  endtask

  task automatic wait_tx_empty(input int budget, output logic timed_out);
    int n;
    n = 0;
    timed_out = 1'b0;
    @(negedge clk);
    while (!tx_empty) begin
      if (n >= budget) begin
        timed_out = 1'b1;
        break;
      end
      n++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if (status !== 7'b1010000) begin
      failures++; $display("FAIL reset_status got=%b exp=1010000", status);
    end
    checks++;
    if (rx_level !== 5'd0 || rx_data !== 8'h00) begin
      failures++; $display("FAIL reset_rx got level=%0d data=%h exp level=0 data=00", rx_level, rx_data);
    end
    @(posedge clk); #1 rst = 1'b0;
    repeat (3) @(posedge clk);
  endtask

  task automatic test_tx_format();
    logic [10:0] bits;
    bits = {1'b1, 1'b0, 8'hA5, 1'b0};
    write_word(8'hA5);
    @(negedge clk);
    checks++;
    if ({tx, tx_empty} !== 2'b10) begin
      failures++; $display("FAIL txfmt_idle_gap got tx=%b empty=%b exp tx=1 empty=0", tx, tx_empty);
    end
    for (int b = 0; b < 11; b++) begin
      for (int c = 0; c < 10; c++) begin
        @(negedge clk);
        checks++;
        if (tx !== bits[b]) begin
          failures++; $display("FAIL txfmt_bit%0d_cyc%0d got=%b exp=%b", b, c, tx, bits[b]);
        end
      end
    end
    @(negedge clk);
    checks++;
    if ({tx, tx_empty} !== 2'b11) begin
      failures++; $display("FAIL txfmt_done got tx=%b empty=%b exp tx=1 empty=1", tx, tx_empty);
    end
  endtask

  task automatic test_loopback();
    logic       samp [400];
    logic [7:0] exp_w [3];
    exp_w[0] = 8'h00; exp_w[1] = 8'hFF; exp_w[2] = 8'h3C;
    loop_en = 1'b1;
    @(posedge clk); #1 tx_wr = 1'b1; tx_data = exp_w[0];
    @(posedge clk); #1 tx_data = exp_w[1];
    @(posedge clk); #1 tx_data = exp_w[2];
    @(posedge clk); #1 tx_wr = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk); samp[i] = tx;
    end
    checks++;
    if ({samp[0], samp[108], samp[109], samp[110], samp[219], samp[220], samp[221]} !== 7'b0110110) begin
      failures++;
      $display("FAIL loop_gap got=%b exp=0110110",
               {samp[0], samp[108], samp[109], samp[110], samp[219], samp[220], samp[221]});
    end
    checks++;
    if (rx_level !== 5'd3) begin
      failures++; $display("FAIL loop_level got=%0d exp=3", rx_level);
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if (rx_valid !== 1'b1 || rx_data !== exp_w[k]) begin
        failures++; $display("FAIL loop_word%0d got valid=%b data=%h exp valid=1 data=%h", k, rx_valid, rx_data, exp_w[k]);
      end
      pop_word();
    end
    @(negedge clk);
    checks++;
    if (status !== 7'b1010000) begin
      failures++; $display("FAIL loop_end_status got=%b exp=1010000", status);
    end
  endtask

  task automatic test_overrun();
    logic [7:0] w [17];
    logic       to;
    for (int i = 0; i < 17; i++) w[i] = 8'(i * 37 + 5);
    loop_en = 1'b1;
    for (int i = 0; i < 17; i++) begin
      @(posedge clk); #1 tx_wr = 1'b1; tx_data = w[i];
    end
    @(posedge clk); #1 tx_wr = 1'b0;
    @(negedge clk);
    checks++;
    if (tx_full !== 1'b1) begin
      failures++; $display("FAIL ovr_tx_full got=%b exp=1", tx_full);
    end
    write_word(8'hEE);
    wait_tx_empty(2500, to);
    checks++;
    if (to !== 1'b0) begin
      failures++; $display("FAIL ovr_tx_drain timeout got=1 exp=0");
    end
    repeat (5) @(negedge clk);
    checks++;
    if (rx_level !== 5'd16 || overrun !== 1'b1 || rx_data !== w[0]) begin
      failures++;
      $display("FAIL ovr_full got level=%0d ovr=%b head=%h exp level=16 ovr=1 head=%h", rx_level, overrun, rx_data, w[0]);
    end
    pulse_clr();
    @(negedge clk);
    checks++;
    if (overrun !== 1'b0) begin
      failures++; $display("FAIL ovr_clear got=%b exp=0", overrun);
    end
    write_word(8'hC3);
    repeat (108) @(posedge clk);
    #1 rx_rd = 1'b1;
    @(posedge clk); #1 rx_rd = 1'b0;
    repeat (5) @(negedge clk);
    checks++;
    if (rx_level !== 5'd16 || overrun !== 1'b0) begin
      failures++; $display("FAIL ovr_pop_push got level=%0d ovr=%b exp level=16 ovr=0", rx_level, overrun);
    end
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      checks++;
      if (rx_data !== ((k < 15) ? w[k+1] : 8'hC3)) begin
        failures++; $display("FAIL ovr_drain%0d got=%h exp=%h", k, rx_data, (k < 15) ? w[k+1] : 8'hC3);
      end
      pop_word();
    end
    @(negedge clk);
    checks++;
    if (status !== 7'b1010000) begin
      failures++; $display("FAIL ovr_end_status got=%b exp=1010000", status);
    end
    loop_en = 1'b0;
  endtask

  task automatic test_errors();
    send_frame(8'h55, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    checks++;
    if (rx_level !== 5'd1 || rx_data !== 8'h55 || {parity_err, frame_err} !== 2'b10) begin
      failures++;
      $display("FAIL err_parity got level=%0d data=%h pe=%b fe=%b exp level=1 data=55 pe=1 fe=0",
               rx_level, rx_data, parity_err, frame_err);
    end
    send_frame(8'h33, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    checks++;
    if (rx_level !== 5'd1 || frame_err !== 1'b1) begin
      failures++; $display("FAIL err_frame got level=%0d fe=%b exp level=1 fe=1", rx_level, frame_err);
    end
    pulse_clr();
    @(negedge clk);
    checks++;
    if ({parity_err, frame_err} !== 2'b00) begin
      failures++; $display("FAIL err_clear got pe=%b fe=%b exp 0 0", parity_err, frame_err);
    end
    send_frame(8'h33, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    checks++;
    if (frame_err !== 1'b1 || rx_level !== 5'd1) begin
      failures++; $display("FAIL err_set_beats_clr got fe=%b level=%0d exp fe=1 level=1", frame_err, rx_level);
    end
    pulse_clr();
    pop_word();
    @(negedge clk);
    checks++;
    if (status !== 7'b1010000) begin
      failures++; $display("FAIL err_end_status got=%b exp=1010000", status);
    end
  endtask

  task automatic test_glitch();
    @(posedge clk); #1 rx_drv = 1'b0;
    repeat (3) @(posedge clk);
    #1 rx_drv = 1'b1;
    repeat (30) @(negedge clk);
    checks++;
    if (status !== 7'b1010000 || rx_level !== 5'd0) begin
      failures++; $display("FAIL glitch_ignored got status=%b level=%0d exp status=1010000 level=0", status, rx_level);
    end
    send_frame(8'h81, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    checks++;
    if (status !== 7'b1011000 || rx_level !== 5'd1 || rx_data !== 8'h81) begin
      failures++;
      $display("FAIL glitch_next_frame got status=%b level=%0d data=%h exp status=1011000 level=1 data=81",
               status, rx_level, rx_data);
    end
  endtask

  task automatic test_reset_mid();
    logic went_low;
    send_frame(8'h0F, 1'b1, 1'b1, 1'b0);
    loop_en = 1'b1;
    write_word(8'h5A);
    repeat (30) @(negedge clk);
    checks++;
    if (tx_empty !== 1'b0 || parity_err !== 1'b1 || rx_level !== 5'd2) begin
      failures++;
      $display("FAIL rstmid_pre got empty=%b pe=%b level=%0d exp empty=0 pe=1 level=2", tx_empty, parity_err, rx_level);
    end
    @(posedge clk); #2 rst = 1'b1;
    #1;
    checks++;
    if (status !== 7'b1010000) begin
      failures++; $display("FAIL rstmid_status got=%b exp=1010000", status);
    end
    checks++;
    if (rx_level !== 5'd0 || rx_data !== 8'h00) begin
      failures++; $display("FAIL rstmid_rx got level=%0d data=%h exp level=0 data=00", rx_level, rx_data);
    end
    @(posedge clk); #1 rst = 1'b0;
    went_low = 1'b0;
    for (int i = 0; i < 150; i++) begin
      @(negedge clk);
      if (tx !== 1'b1) went_low = 1'b1;
    end
    checks++;
    if (went_low !== 1'b0 || tx_empty !== 1'b1) begin
      failures++; $display("FAIL rstmid_after got low_seen=%b empty=%b exp low_seen=0 empty=1", went_low, tx_empty);
    end
  endtask

  initial begin
    test_reset();
    test_tx_format();
    test_loopback();
    test_overrun();
    test_errors();
    test_glitch();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2ms;
    failures++;
    $display("FAIL watchdog got=timeout exp=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

endmodule
